// File: rtl/blink_pattern_gen.sv
// N-channel blink pattern generator: free-running tick divider plus an
// IDLE/ON/OFF sequencer that plays an in-phase or chase pattern.
module blink_pattern_gen #(
  parameter int TICK_DIV = 50_000_000,
  parameter int N_CH     = 4,
  parameter int CNT_W    = 8,
  parameter int REP_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_on_ticks,
  input  logic [CNT_W-1:0] i_off_ticks,
  input  logic [REP_W-1:0] i_repeat,
  input  logic [N_CH-1:0]  i_ch_mask,
  input  logic             i_mode,
  output logic [N_CH-1:0]  o_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_tick
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int POS_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  state_t             r_state;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic               r_tick;
  logic [CNT_W-1:0]   r_phase_cnt;
  logic [CNT_W-1:0]   r_on_len;
  logic [CNT_W-1:0]   r_off_len;
  logic [REP_W-1:0]   r_rep_cnt;
  logic [N_CH-1:0]    r_mask;
  logic               r_mode;
  logic [POS_W-1:0]   r_pos;
  logic [N_CH-1:0]    r_out;
  logic               r_busy;
  logic               r_done;

  logic [POS_W-1:0]   w_pos_next;

  // A programmed duration of zero plays as a single tick.
  function automatic logic [CNT_W-1:0] dur(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  function automatic logic [N_CH-1:0] pattern(input logic [N_CH-1:0]  mask,
                                              input logic             mode,
                                              input logic [POS_W-1:0] pos);
    logic [N_CH-1:0] sel;
    for (int i = 0; i < N_CH; i++) begin
      sel[i] = !mode || (POS_W'(i) == pos);
    end
    return mask & sel;
  endfunction

  // Chase position only moves in chase mode; it wraps through masked channels too.
  always_comb begin
    w_pos_next = r_pos;
    if (r_mode) begin
      w_pos_next = (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else if (r_tick_cnt == TICK_MAX) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
      r_tick     <= 1'b0;
    end
  end

  // r_rep_cnt == 0 means "run until stopped"; otherwise it counts periods left.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= '0;
      r_on_len    <= '0;
      r_off_len   <= '0;
      r_rep_cnt   <= '0;
      r_mask      <= '0;
      r_mode      <= 1'b0;
      r_pos       <= '0;
      r_out       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_out  <= '0;
          r_busy <= 1'b0;
          if (i_start && !i_stop) begin
            r_on_len    <= dur(i_on_ticks);
            r_off_len   <= dur(i_off_ticks);
            r_rep_cnt   <= i_repeat;
            r_mask      <= i_ch_mask;
            r_mode      <= i_mode;
            r_phase_cnt <= dur(i_on_ticks);
            r_pos       <= '0;
            r_out       <= pattern(i_ch_mask, i_mode, '0);
            r_busy      <= 1'b1;
            r_state     <= S_ON;
          end
        end
        S_ON: begin
          if (i_stop) begin
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_tick) begin
            if (r_phase_cnt == CNT_W'(1)) begin
              r_phase_cnt <= r_off_len;
              r_out       <= '0;
              r_state     <= S_OFF;
            end else begin
              r_phase_cnt <= r_phase_cnt - 1'b1;
            end
          end
        end
        S_OFF: begin
          if (i_stop) begin
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_tick) begin
            if (r_phase_cnt == CNT_W'(1)) begin
              r_pos <= w_pos_next;
              if (r_rep_cnt == REP_W'(1)) begin
                r_out   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                if (r_rep_cnt != '0) begin
                  r_rep_cnt <= r_rep_cnt - 1'b1;
                end
                r_phase_cnt <= r_on_len;
                r_out       <= pattern(r_mask, r_mode, w_pos_next);
                r_state     <= S_ON;
              end
            end else begin
              r_phase_cnt <= r_phase_cnt - 1'b1;
            end
          end
        end
        default: begin
          r_out   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_out  = r_out;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_tick = r_tick;

endmodule

// File: tb/tb_blink_pattern_gen.sv
// Scoreboard bench for blink_pattern_gen: the stimulus side pushes the per-tick
// pattern a run should show, the monitor pops one entry per o_tick / o_done.
module tb_blink_pattern_gen;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop;
  logic [7:0] on_t, off_t, rep;
  logic [3:0] mask;
  logic       mode;
  logic [3:0] out;
  logic       busy, done, tick;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         is_done;
    logic [3:0] val;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  blink_pattern_gen #(.TICK_DIV(TD), .N_CH(4), .CNT_W(8), .REP_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_on_ticks(on_t), .i_off_ticks(off_t), .i_repeat(rep),
    .i_ch_mask(mask), .i_mode(mode),
    .o_out(out), .o_busy(busy), .o_done(done), .o_tick(tick)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: period p shows the mask (in phase) or the mask bit at p mod 4 (chase)
  // for max(on,1) ticks, then dark for max(off,1) ticks; done follows the last period.
  task automatic push_run(input int on, input int off, input int r, input logic [3:0] m,
                          input bit md, input int cont_periods, input int tail_ticks);
    int periods;
    logic [3:0] one;
    logic [3:0] v;
    exp_t e;
    periods = (r == 0) ? cont_periods : r;
    one = 4'b0001;
    for (int p = 0; p < periods; p++) begin
      v = md ? (m & (one << (p % 4))) : m;
      for (int t = 0; t < ((on == 0) ? 1 : on); t++) begin
        e.is_done = 1'b0; e.val = v; sb.push_back(e);
      end
      for (int t = 0; t < ((off == 0) ? 1 : off); t++) begin
        e.is_done = 1'b0; e.val = 4'b0000; sb.push_back(e);
      end
    end
    for (int t = 0; t < tail_ticks; t++) begin
      v = md ? (m & (one << (periods % 4))) : m;
      e.is_done = 1'b0; e.val = v; sb.push_back(e);
    end
    if (r != 0) begin
      e.is_done = 1'b1; e.val = 4'b0000; sb.push_back(e);
    end
  endtask

  task automatic set_cfg(input int on, input int off, input int r, input logic [3:0] m, input bit md);
    on_t = 8'(on); off_t = 8'(off); rep = 8'(r); mask = m; mode = md;
  endtask

  // Called at posedge+1; the start is sampled at the next edge, after which the model is queued.
  task automatic start_run(input int on, input int off, input int r, input logic [3:0] m,
                           input bit md, input int cont_periods, input int tail_ticks);
    set_cfg(on, off, r, m, md);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_run(on, off, r, m, md, cont_periods, tail_ticks);
  endtask

  // Waits until the scoreboard empties; with chaos, pokes start and config mid-run.
  task automatic wait_drain(input string name, input int budget, input bit chaos);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (chaos) begin
        if (sb.size() > 2) begin
          start = 1'($urandom_range(0, 1));
          on_t  = 8'($urandom_range(0, 255));
          off_t = 8'($urandom_range(0, 255));
          rep   = 8'($urandom_range(0, 255));
          mask  = 4'($urandom_range(0, 15));
          mode  = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk({name, "_drain_left"}, sb.size(), 0);
  endtask

  task automatic release_and_first_tick(input string name);
    int n;
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tick && n < 20);
    chk({name, "_first_tick_cycles"}, n, TD);
  endtask

  // Monitor: one scoreboard entry per tick strobe or done pulse.
  initial begin
    exp_t e;
    int since;
    bit seen;
    since = 0;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        since = 0;
        seen = 1'b0;
      end else begin
        since++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", done, 1'b0);
          end else begin
            e = sb.pop_front();
            chk("done_expected_here", 1'(e.is_done), 1'b1);
            chk("busy_at_done", busy, 1'b0);
          end
        end
        if (tick) begin
          if (seen) chk("tick_period", since, TD);
          seen = 1'b1;
          since = 0;
          if (sb.size() == 0) begin
            chk("idle_out", out, 4'b0000);
            chk("idle_busy", busy, 1'b0);
          end else begin
            e = sb.pop_front();
            chk("tick_not_done", 1'(e.is_done), 1'b0);
            if (!e.is_done) begin
              chk("pattern_out", out, e.val);
              chk("pattern_busy", busy, 1'b1);
            end
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    set_cfg(0, 0, 0, 4'b0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", out, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tick", tick, 1'b0);
    release_and_first_tick("por");

    start_run(2, 1, 3, 4'b1011, 1'b0, 0, 0);
    wait_drain("inphase", 500, 1'b0);
    start_run(1, 1, 5, 4'b1111, 1'b1, 0, 0);
    wait_drain("chase_full", 500, 1'b0);
    start_run(1, 1, 5, 4'b0101, 1'b1, 0, 0);
    wait_drain("chase_masked", 500, 1'b0);
    start_run(0, 0, 1, 4'b1110, 1'b0, 0, 0);
    wait_drain("zero_durations", 500, 1'b0);
    start_run(2, 2, 2, 4'b0000, 1'b1, 0, 0);
    wait_drain("zero_mask", 500, 1'b0);

    for (int k = 0; k < 8; k++) begin
      start_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 4)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 0, 0);
      wait_drain("random_chaos", 1000, 1'b1);
    end

    // Start held high through completion re-triggers a second identical run.
    set_cfg(1, 2, 2, 4'b1100, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    push_run(1, 2, 2, 4'b1100, 1'b0, 0, 0);
    push_run(1, 2, 2, 4'b1100, 1'b0, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 500);
    chk("retrigger_done_seen", done, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("retrigger_busy", busy, 1'b1);
    wait_drain("retrigger", 500, 1'b0);

    // Continuous: ten periods with no done, then stop in ON.
    start_run(2, 1, 0, 4'b0110, 1'b0, 10, 1);
    wait_drain("continuous", 1000, 1'b0);
    chk("cont_busy_before_stop", busy, 1'b1);
    chk("cont_out_before_stop", out, 4'b0110);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_out", out, 4'b0000);
    chk("stop_busy", busy, 1'b0);
    chk("stop_done", done, 1'b0);
    repeat (3 * TD) @(posedge clk);
    #1;

    // Start and stop together in IDLE start nothing.
    set_cfg(1, 1, 2, 4'b1111, 1'b0);
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    chk("startstop_busy", busy, 1'b0);
    chk("startstop_out", out, 4'b0000);
    repeat (2 * TD) @(posedge clk);
    #1;
    chk("startstop_busy_later", busy, 1'b0);

    // Asynchronous reset in the middle of an ON phase.
    start_run(2, 1, 3, 4'b1011, 1'b0, 0, 0);
    n = 0;
    while (sb.size() > 9 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("pre_reset_out", out, 4'b1011);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out", out, 4'b0000);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_tick", tick, 1'b0);
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    release_and_first_tick("after_rst");
    start_run(2, 1, 3, 4'b1011, 1'b0, 0, 0);
    wait_drain("inphase_after_rst", 500, 1'b0);

    repeat (2 * TD) @(posedge clk);
    #1;
    chk("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
